scan_chain_driver: RTL and testbench

//  Scan-side test driver: the controlling end of the scan interface exposed by the scan-enabled

---
 rtl/scan_chain_driver.sv | 160 ++++++++++++++++
 tb/tb_scan_chain_driver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_driver.sv
// Scan-side test driver: loads a pattern into a scan chain, runs functional capture cycles,
// then unloads and deserialises the chain state. Optional compare: define SCAN_DRV_COMPARE_EN.
module scan_chain_driver #(
    parameter int unsigned CHAIN_LEN      = 4,
    parameter int unsigned CAPTURE_CYCLES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [CHAIN_LEN-1:0] i_pattern,
    input  logic [CHAIN_LEN-1:0] i_expected,
    output logic                 o_scan_en,
    output logic                 o_scan_si,
    input  logic                 i_scan_so,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_response,
    output logic                 o_mismatch
);

    localparam int unsigned MAX_PHASE = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(MAX_PHASE + 1);

    // Counter holds cycles remaining in the phase; zero marks the last cycle.
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CHAIN_LEN-1:0] r_pat;
    logic                 r_scan_en;
    logic                 r_scan_si;
    logic                 r_busy;
    logic                 r_done;
    logic [CHAIN_LEN-1:0] r_response;

    logic                 w_accept;
    logic                 w_cnt_zero;
    logic                 w_unload_last;
    logic [CHAIN_LEN-1:0] w_pat_shl;
    logic [CHAIN_LEN-1:0] w_resp_next;

    assign w_accept      = (r_state == S_IDLE) && i_start;
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_unload_last = (r_state == S_UNLOAD) && w_cnt_zero;
    assign w_pat_shl     = r_pat << 1;
    // First bit unloaded is the last flop, so it ends up in the MSB.
    assign w_resp_next   = (r_response << 1) | CHAIN_LEN'(i_scan_so);

    // Sequencer: state, phase counter and all registered scan/handshake outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pat      <= '0;
            r_scan_en  <= 1'b0;
            r_scan_si  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_response <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_LOAD;
                        r_cnt      <= SHIFT_LAST;
                        r_pat      <= i_pattern;
                        r_scan_en  <= 1'b1;
                        r_scan_si  <= i_pattern[CHAIN_LEN-1];
                        r_busy     <= 1'b1;
                        r_response <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_cnt_zero) begin
                        r_state   <= S_CAPTURE;
                        r_cnt     <= CAP_LAST;
                        r_scan_en <= 1'b0;
                        r_scan_si <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt - CNT_W'(1);
                        r_pat     <= w_pat_shl;
                        r_scan_si <= w_pat_shl[CHAIN_LEN-1];
                    end
                end
                S_CAPTURE: begin
                    if (w_cnt_zero) begin
                        r_state   <= S_UNLOAD;
                        r_cnt     <= SHIFT_LAST;
                        r_scan_en <= 1'b1;
                        r_scan_si <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_UNLOAD: begin
                    r_response <= w_resp_next;
                    if (w_cnt_zero) begin
                        r_state   <= S_DONE;
                        r_cnt     <= '0;
                        r_scan_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_scan_en <= 1'b0;
                    r_scan_si <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_DRV_COMPARE_EN
    logic [CHAIN_LEN-1:0] r_expected;
    logic                 r_mismatch;

    // Expected state is captured with the pattern; the verdict lands together with done.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_expected <= '0;
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_expected <= i_expected;
            r_mismatch <= 1'b0;
        end else if (w_unload_last) begin
            r_mismatch <= (w_resp_next != r_expected);
        end
    end

    assign o_mismatch = r_mismatch;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (^i_expected) ^ w_accept ^ w_unload_last;
    assign o_mismatch   = 1'b0;
`endif

    assign o_scan_en  = r_scan_en;
    assign o_scan_si  = r_scan_si;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_response = r_response;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: two drivers (capture 1 and 3 cycles) each driving a 4-bit scan counter model.
module tb_scan_chain_driver;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic [N-1:0] pattern;
    logic [N-1:0] expected;

    logic         se1, si1, so1, busy1, done1, mm1;
    logic [N-1:0] resp1;
    logic         se3, si3, so3, busy3, done3, mm3;
    logic [N-1:0] resp3;

    logic [N-1:0] cnt1, cnt3;

    scan_chain_driver #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_pattern(pattern), .i_expected(expected),
        .o_scan_en(se1), .o_scan_si(si1), .i_scan_so(so1), .o_busy(busy1), .o_done(done1),
        .o_response(resp1), .o_mismatch(mm1)
    );

    scan_chain_driver #(.CHAIN_LEN(N), .CAPTURE_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_pattern(pattern), .i_expected(expected),
        .o_scan_en(se3), .o_scan_si(si3), .i_scan_so(so3), .o_busy(busy3), .o_done(done3),
        .o_response(resp3), .o_mismatch(mm3)
    );

    // Scan counter models: shift toward MSB in scan mode, increment in functional mode.
    assign so1 = cnt1[N-1];
    assign so3 = cnt3[N-1];
    always_ff @(posedge clk) begin
        if (!rst_n)   cnt1 <= '0;
        else if (se1) cnt1 <= {cnt1[N-2:0], si1};
        else          cnt1 <= cnt1 + 4'd1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n)   cnt3 <= '0;
        else if (se3) cnt3 <= {cnt3[N-2:0], si3};
        else          cnt3 <= cnt3 + 4'd1;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0] resp;
        logic         mm;
        int unsigned  due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    typedef struct {
        logic [N-1:0] pat;
        logic [N-1:0] exp_in;
        logic [N-1:0] r1;
        logic [N-1:0] r3;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard consumers: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("c1_unexpected_done", 32'(done1), 32'd0);
            end else begin
                e = q1.pop_front();
                chk("c1_response", 32'(resp1), 32'(e.resp));
                chk("c1_mismatch", 32'(mm1), 32'(e.mm));
                chk("c1_done_cycle", cyc, e.due);
                chk("c1_done_idle_outs", 32'({busy1, se1}), 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (done3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("c3_unexpected_done", 32'(done3), 32'd0);
            end else begin
                e = q3.pop_front();
                chk("c3_response", 32'(resp3), 32'(e.resp));
                chk("c3_mismatch", 32'(mm3), 32'(e.mm));
                chk("c3_done_cycle", cyc, e.due);
                chk("c3_done_idle_outs", 32'({busy3, se3}), 32'd0);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start and push both expectations; returns in load cycle 0.
    task automatic send(input logic [N-1:0] p, input logic [N-1:0] x,
                        input logic [N-1:0] r1, input logic [N-1:0] r3);
        exp_t e;
        start    = 1'b1;
        pattern  = p;
        expected = x;
        e.resp = r1;
`ifdef SCAN_DRV_COMPARE_EN
        e.mm = (r1 != x);
`else
        e.mm = 1'b0;
`endif
        e.due = cyc + 1 + 2 * N + 1;
        q1.push_back(e);
        e.resp = r3;
`ifdef SCAN_DRV_COMPARE_EN
        e.mm = (r3 != x);
`else
        e.mm = 1'b0;
`endif
        e.due = cyc + 1 + 2 * N + 3;
        q3.push_back(e);
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q1.size() + q3.size()), 32'd0);
        step();
    endtask

    vec_t vecs[6];

    initial begin : main
        logic [N-1:0] p;

        vecs[0] = '{pat: 4'b0101, exp_in: 4'b0110, r1: 4'b0110, r3: 4'b1000};
        vecs[1] = '{pat: 4'b0101, exp_in: 4'b0111, r1: 4'b0110, r3: 4'b1000};
        vecs[2] = '{pat: 4'b1111, exp_in: 4'b0000, r1: 4'b0000, r3: 4'b0010};
        vecs[3] = '{pat: 4'b0010, exp_in: 4'b0101, r1: 4'b0011, r3: 4'b0101};
        vecs[4] = '{pat: 4'b0000, exp_in: 4'b0001, r1: 4'b0001, r3: 4'b0011};
        vecs[5] = '{pat: 4'b1001, exp_in: 4'b1111, r1: 4'b1010, r3: 4'b1100};

        rst_n    = 1'b0;
        start    = 1'b1;
        pattern  = 4'b1111;
        expected = 4'b0000;

        // Reset held with start asserted: everything stays quiet.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_busy1", 32'(busy1), 32'd0);
            chk("rst_outs1", 32'({se1, si1, done1, mm1, resp1}), 32'd0);
            chk("rst_busy3", 32'(busy3), 32'd0);
            chk("rst_outs3", 32'({se3, si3, done3, mm3, resp3}), 32'd0);
        end
        step();
        rst_n = 1'b1;
        start = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].pat, vecs[i].exp_in, vecs[i].r1, vecs[i].r3);
            if (i == 0) begin
                p = vecs[i].pat;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("load_scan_en", 32'(se1), 32'd1);
                    chk("load_scan_si", 32'(si1), 32'(p[3-k]));
                    chk("load_busy", 32'(busy1), 32'd1);
                end
                @(negedge clk);
                chk("capture_scan_en", 32'({se1, si1}), 32'd0);
                chk("capture_busy", 32'(busy1), 32'd1);
            end
            wait_idle();
        end

        // Start re-pulsed during LOAD must be ignored.
        send(4'b0011, 4'b0100, 4'b0100, 4'b0110);
        step();
        start   = 1'b1;
        pattern = 4'b1111;
        step();
        start = 1'b0;
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_extra_done", 32'({done1, done3}), 32'd0);
        end
        step();

        // Reset in the second unload cycle aborts without a response.
        start    = 1'b1;
        pattern  = 4'b1000;
        expected = 4'b0000;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        chk("abort_pre_scan_en", 32'({se1, busy1}), 32'd3);
        chk("abort_pre_partial", 32'(resp1), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outs1", 32'({se1, si1, busy1, done1, mm1}), 32'd0);
        chk("abort_resp1", 32'(resp1), 32'd0);
        chk("abort_outs3", 32'({se3, si3, busy3, done3, mm3, resp3}), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({done1, done3, busy1, busy3}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
